// File: rtl/r3_unpack.sv
// Unpacks a byte-packed ternary polynomial (four 2-bit codes per byte, LSB-first)
// into one CW-bit word per coefficient in the coefficient RAM.
module r3_unpack #(
    parameter int P  = 757,
    parameter int NB = 190,
    parameter int CW = 13,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          byte_rd_en,
    output logic [7:0]    byte_addr,
    input  logic [7:0]    byte_data,
    output logic          coef_we,
    output logic [AW-1:0] coef_addr,
    output logic [CW-1:0] coef_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Codes actually carried by the final byte; the bits above them are padding.
    localparam int USED = P - 4 * (NB - 1);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

    state_t          state;
    logic [7:0]      byte_idx;
    logic [AW-1:0]   coef_idx;
    logic [1:0]      k;
    logic [7:0]      sh;

    function automatic logic [CW-1:0] code_word(input logic [1:0] code);
        return (code == 2'd3) ? CW'(1) : {{(CW-2){1'b0}}, code};
    endfunction

    function automatic logic pad_bad(input logic [7:0] b);
        return (b >> (2 * USED)) != 8'd0;
    endfunction

    // Shift register is pure data: loaded in LAT before any use, so no reset.
    always_ff @(posedge clk) begin
        if (state == LAT)
            sh <= byte_data;
        else if (state == WR)
            sh <= sh >> 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            coef_idx   <= '0;
            k          <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_rd_en <= 1'b0;
            byte_addr  <= '0;
            coef_we    <= 1'b0;
            coef_addr  <= '0;
            coef_data  <= '0;
        end else begin
            byte_rd_en <= 1'b0;
            coef_we    <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_idx   <= '0;
                        coef_idx   <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        byte_rd_en <= 1'b1;
                        byte_addr  <= '0;
                        state      <= RD;
                    end
                end
                RD: begin
                    state <= LAT;
                end
                LAT: begin
                    k         <= '0;
                    coef_we   <= 1'b1;
                    coef_addr <= coef_idx;
                    coef_data <= code_word(byte_data[1:0]);
                    if (byte_idx == 8'(NB - 1) && pad_bad(byte_data))
                        err <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    if (sh[1:0] == 2'd3)
                        err <= 1'b1;
                    coef_idx <= coef_idx + 1'b1;
                    k        <= k + 2'd1;
                    if (coef_idx == AW'(P - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (k == 2'd3) begin
                        byte_idx   <= byte_idx + 8'd1;
                        byte_rd_en <= 1'b1;
                        byte_addr  <= byte_idx + 8'd1;
                        state      <= RD;
                    end else begin
                        // Outputs for the next write are staged from the code after this shift.
                        coef_we   <= 1'b1;
                        coef_addr <= coef_idx + 1'b1;
                        coef_data <= code_word(sh[3:2]);
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    byte_addr <= '0;
                    coef_addr <= '0;
                    coef_data <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r3_unpack.sv
// Bench for r3_unpack: byte RAM model, per-cycle schedule checks against a
// coefficient/timing reference, table vectors and randomized polynomials.
module tb_r3_unpack;

    localparam int P        = 757;
    localparam int NB       = 190;
    localparam int CW       = 13;
    localparam int AW       = 11;
    localparam int DONE_REL = 1138;
    localparam int LAST_LAT = 1136;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          byte_rd_en;
    logic [7:0]    byte_addr;
    logic [7:0]    byte_data = '0;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0] mem [NB];
    int         cram [P];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    typedef struct {
        string      name;
        logic [7:0] fill;
        logic [7:0] b0;
        logic [7:0] blast;
        int         c0, c1, c2, c3, clast;
        int         e_err;
    } vec_t;

    vec_t vecs [5];

    r3_unpack #(.P(P), .NB(NB), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_rd_en(byte_rd_en), .byte_addr(byte_addr), .byte_data(byte_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (byte_rd_en)
            byte_data <= (int'(byte_addr) < NB) ? mem[byte_addr] : 8'h00;
    end

    function automatic int code_of(int i);
        return int'(mem[i / 4] >> (2 * (i % 4))) & 3;
    endfunction

    function automatic int coef_of(int i);
        int c = code_of(i);
        return (c == 3) ? 1 : c;
    endfunction

    function automatic int wr_cyc(int i);
        return 3 + 6 * (i / 4) + (i % 4);
    endfunction

    function automatic bit any_out();
        return byte_rd_en | coef_we | done | busy | err | (|byte_addr) | (|coef_addr) | (|coef_data);
    endfunction

    task automatic check(input string name, input int act, input int exp, input string detail = "");
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d %s", name, act, exp, detail);
        end
    endtask

    // Enter at a negedge with start already driven high; leaves at the negedge of cycle DONE_REL+1.
    task automatic run_check(input string name, input int hold_until, input int p1, input int p2,
                             input int abort_at, output int err_final);
        int    nwr = 0, nrd = 0, nd = 0, done_rel = -1;
        int    bad_wr = 0, bad_rd = 0, bad_busy = 0, bad_err = 0;
        int    first_c3 = 1 << 30;
        bit    pad, aborted = 0, exp_err;
        string wmsg = "", rmsg = "", emsg = "";
        pad = ((P % 4) != 0) && ((mem[NB-1] >> (2 * (P % 4))) != 8'd0);
        for (int i = 0; i < P; i++) begin
            cram[i] = -1;
            if (code_of(i) == 3 && wr_cyc(i) < first_c3) first_c3 = wr_cyc(i);
        end
        for (int rel = 1; rel <= DONE_REL + 1; rel++) begin
            @(negedge clk);
            if (abort_at != 0 && rel == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, "_abort_outputs"}, int'(any_out()), 0);
                aborted = 1;
                break;
            end
            if (coef_we) begin
                if (int'(coef_addr) < P) cram[coef_addr] = int'(coef_data);
                if (nwr >= P || int'(coef_addr) != nwr || int'(coef_data) != coef_of(nwr) || rel != wr_cyc(nwr)) begin
                    if (bad_wr == 0)
                        wmsg = $sformatf("(first: n=%0d addr=%0d data=%0d cycle=%0d)", nwr, coef_addr, coef_data, rel);
                    bad_wr++;
                end
                nwr++;
            end
            if (byte_rd_en) begin
                if (int'(byte_addr) != nrd || rel != 1 + 6 * nrd) begin
                    if (bad_rd == 0) rmsg = $sformatf("(first: n=%0d addr=%0d cycle=%0d)", nrd, byte_addr, rel);
                    bad_rd++;
                end
                nrd++;
            end
            if (done) begin
                nd++;
                done_rel = rel;
            end
            if (busy != (rel <= DONE_REL)) bad_busy++;
            exp_err = (rel > first_c3) || (pad && rel > LAST_LAT);
            if (err != exp_err) begin
                if (bad_err == 0) emsg = $sformatf("(first at cycle %0d, err=%0d)", rel, err);
                bad_err++;
            end
            if (rel == DONE_REL + 1)
                check({name, "_idle_after"}, int'(any_out() & ~err), 0);
            start = (rel <= hold_until) || (rel == p1) || (rel == p2);
        end
        check({name, "_write_seq"}, bad_wr, 0, wmsg);
        check({name, "_read_seq"}, bad_rd, 0, rmsg);
        check({name, "_busy"}, bad_busy, 0);
        check({name, "_err_track"}, bad_err, 0, emsg);
        if (aborted) begin
            start = 1'b0;
            repeat (2) @(negedge clk);
            check({name, "_in_reset"}, int'(any_out()), 0);
            rst_n = 1'b1;
        end else begin
            check({name, "_write_count"}, nwr, P);
            check({name, "_read_count"}, nrd, NB);
            check({name, "_done_pulses"}, nd, 1);
            check({name, "_done_cycle"}, done_rel, DONE_REL);
        end
        err_final = int'(err);
    endtask

    task automatic load(input logic [7:0] fill, input logic [7:0] b0, input logic [7:0] blast);
        for (int i = 0; i < NB; i++) mem[i] = fill;
        mem[0]    = b0;
        mem[NB-1] = blast;
    endtask

    initial begin
        int         bad, ef;
        logic [7:0] v;

        vecs[0] = '{"all_zero",  8'h55, 8'h55, 8'h01, 1, 1, 1, 1, 1, 0};
        vecs[1] = '{"order",     8'h55, 8'h9C, 8'h01, 0, 1, 1, 2, 1, 1};
        vecs[2] = '{"pad",       8'h55, 8'h55, 8'h06, 1, 1, 1, 1, 2, 1};
        vecs[3] = '{"codes0123", 8'h55, 8'hE4, 8'h02, 0, 1, 2, 1, 2, 1};
        vecs[4] = '{"all_neg",   8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0};

        // Reset and idle
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (any_out()) bad++;
        end
        check("reset_outputs", bad, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (any_out()) bad++;
        end
        check("idle_no_strobes", bad, 0);

        // Table vectors; an erroring vector precedes a clean one so the start-clear of err is exercised
        for (int t = 0; t < 5; t++) begin
            load(vecs[t].fill, vecs[t].b0, vecs[t].blast);
            start = 1'b1;
            run_check(vecs[t].name, 0, 0, 0, 0, ef);
            check({vecs[t].name, "_coef0"}, cram[0], vecs[t].c0);
            check({vecs[t].name, "_coef1"}, cram[1], vecs[t].c1);
            check({vecs[t].name, "_coef2"}, cram[2], vecs[t].c2);
            check({vecs[t].name, "_coef3"}, cram[3], vecs[t].c3);
            check({vecs[t].name, "_coef_last"}, cram[P-1], vecs[t].clast);
            check({vecs[t].name, "_err_final"}, ef, vecs[t].e_err);
        end

        // Abort mid-run, then restart cleanly
        load(8'h55, 8'h9C, 8'h01);
        start = 1'b1;
        run_check("abort", 0, 0, 0, 500, ef);
        load(8'h55, 8'h55, 8'h01);
        start = 1'b1;
        run_check("restart", 0, 0, 0, 0, ef);
        check("restart_err", ef, 0);

        // Start pulses while busy are ignored
        load(8'h55, 8'h9C, 8'h06);
        start = 1'b1;
        run_check("ignored_start", 0, 10, 600, 0, ef);

        // Start held through DONE: second run chains with RD at cycle 1140
        load(8'h55, 8'h55, 8'h01);
        start = 1'b1;
        run_check("held_start_a", DONE_REL + 1, 0, 0, 0, ef);
        run_check("held_start_b", 0, 0, 0, 0, ef);

        // Randomized polynomials checked against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < NB; b++) begin
                v = '0;
                for (int j = 0; j < 4; j++)
                    v = v | 8'(((($urandom_range(0, 49) == 0) ? 3 : $urandom_range(0, 2))) << (2 * j));
                mem[b] = v;
            end
            if ($urandom_range(0, 1) == 0) mem[NB-1] = mem[NB-1] & 8'h03;
            start = 1'b1;
            run_check($sformatf("random%0d", r), 0, 0, 0, 0, ef);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
